// File: rtl/ndma_xfer_ctrl_if.sv
// ndma_xfer_ctrl_if: copy-sequencer bundle (command, read/write manager handshakes, status); irq pair present when NDMA_XFER_IRQ_EN is defined
interface ndma_xfer_ctrl_if #(parameter int LEN_W = 16);
    logic             start_i;
    logic             abort_i;
    logic [31:0]      src_addr_i;
    logic [31:0]      dst_addr_i;
    logic [LEN_W-1:0] len_i;
    logic             rd_req_o;
    logic [31:0]      rd_addr_o;
    logic             rd_busy_i;
    logic             rd_valid_i;
    logic [31:0]      rd_data_i;
    logic             wr_req_o;
    logic [31:0]      wr_addr_o;
    logic [31:0]      wr_data_o;
    logic             wr_busy_i;
    logic             wr_done_i;
    logic             busy_o;
    logic             done_o;
    logic             aborted_o;
`ifdef NDMA_XFER_IRQ_EN
    logic             irq_o;
    logic             irq_clr_i;
`endif
    modport master (
        input  start_i, abort_i, src_addr_i, dst_addr_i, len_i,
        input  rd_busy_i, rd_valid_i, rd_data_i, wr_busy_i, wr_done_i,
`ifdef NDMA_XFER_IRQ_EN
        input  irq_clr_i,
        output irq_o,
`endif
        output rd_req_o, rd_addr_o, wr_req_o, wr_addr_o, wr_data_o,
        output busy_o, done_o, aborted_o
    );
    modport slave (
        output start_i, abort_i, src_addr_i, dst_addr_i, len_i,
        output rd_busy_i, rd_valid_i, rd_data_i, wr_busy_i, wr_done_i,
`ifdef NDMA_XFER_IRQ_EN
        output irq_clr_i,
        input  irq_o,
`endif
        input  rd_req_o, rd_addr_o, wr_req_o, wr_addr_o, wr_data_o,
        input  busy_o, done_o, aborted_o
    );
endinterface

// File: rtl/ndma_xfer_ctrl.sv
// ndma_xfer_ctrl: word-by-word read-then-write copy sequencer; NDMA_XFER_IRQ_EN adds a sticky completion interrupt
module ndma_xfer_ctrl #(
    parameter int LEN_W = 16
) (
    input logic clk_i,
    input logic rst_ni,
    ndma_xfer_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} state_t;
    state_t           state, state_nx;
    logic [31:0]      src, dst, data_buf;
    logic [LEN_W-1:0] remaining;
    logic             pend, aborted, rd_req, wr_req, abort_take;
    // next state, request qualification and abort resolution
    always_comb begin
        state_nx   = state;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        abort_take = 1'b0;
        case (state)
            IDLE:    if (bus.start_i) state_nx = (bus.len_i == '0) ? FIN : RD_REQ;
            RD_REQ: begin
                abort_take = bus.abort_i;
                rd_req     = !bus.abort_i && !bus.rd_busy_i;
                state_nx   = bus.abort_i ? FIN : (rd_req ? RD_WAIT : RD_REQ);
            end
            RD_WAIT: if (bus.rd_valid_i) state_nx = WR_REQ;
            WR_REQ: begin
                abort_take = bus.abort_i;
                wr_req     = !bus.abort_i && !bus.wr_busy_i;
                state_nx   = bus.abort_i ? FIN : (wr_req ? WR_WAIT : WR_REQ);
            end
            WR_WAIT: if (bus.wr_done_i) begin
                abort_take = pend || bus.abort_i;
                state_nx   = (remaining == LEN_W'(1) || abort_take) ? FIN : RD_REQ;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state, transfer context, buffer and abort tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            data_buf  <= '0;
            remaining <= '0;
            pend      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start_i) begin
                src       <= bus.src_addr_i;
                dst       <= bus.dst_addr_i;
                remaining <= bus.len_i;
                aborted   <= 1'b0;
                pend      <= 1'b0;
            end
            if (state == RD_WAIT && bus.rd_valid_i) data_buf <= bus.rd_data_i;
            if (state == WR_WAIT && bus.wr_done_i) begin
                src       <= src + 32'd4;
                dst       <= dst + 32'd4;
                remaining <= remaining - LEN_W'(1);
            end
            if ((state == RD_WAIT || state == WR_WAIT) && bus.abort_i) pend <= 1'b1;
            if (state == FIN) pend <= 1'b0;
            if (abort_take) aborted <= 1'b1;
        end
    end
    assign bus.rd_req_o  = rd_req;
    assign bus.rd_addr_o = rd_req ? src : '0;
    assign bus.wr_req_o  = wr_req;
    assign bus.wr_addr_o = wr_req ? dst : '0;
    assign bus.wr_data_o = data_buf;
    assign bus.busy_o    = state != IDLE;
    assign bus.done_o    = state == FIN;
    assign bus.aborted_o = aborted;
`ifdef NDMA_XFER_IRQ_EN
    logic irq;
    // sticky interrupt: a new completion overrides a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq <= 1'b0;
        else         irq <= bus.done_o || (irq && !bus.irq_clr_i);
    end
    assign bus.irq_o = irq || bus.done_o;
`endif
endmodule

// File: tb/tb_ndma_xfer_ctrl.sv
// tb_ndma_xfer_ctrl: scoreboard bench for ndma_xfer_ctrl with one-cycle-response memory managers
module tb_ndma_xfer_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] rd_q[$];
    logic [63:0] wr_q[$];
    logic [2:0]  done_q[$];
    ndma_xfer_ctrl_if #(.LEN_W(16)) bus();
    ndma_xfer_ctrl #(.LEN_W(16)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // read/write manager model: one-cycle response to each request
    initial begin
        logic rv, wv;
        logic [31:0] ra;
        forever begin
            @(negedge clk);
            rv = bus.rd_req_o;
            ra = bus.rd_addr_o;
            wv = bus.wr_req_o;
            @(posedge clk);
            #1;
            bus.rd_valid_i = rv;
            bus.rd_data_i  = rv ? mem(ra) : 32'h0;
            bus.wr_done_i  = wv;
        end
    end

    // monitor: pops expected accesses and completions as the DUT presents them
    initial begin
        logic prev_req = 1'b0, pwd = 1'b0, pst = 1'b0;
        logic [31:0] er;
        logic [63:0] ew;
        logic [2:0]  ed;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.rd_req_o) begin
                    if (rd_q.size() == 0) chk("rd_unexpected", {32'h0, bus.rd_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    else begin
                        er = rd_q.pop_front();
                        chk("rd_addr", {32'h0, bus.rd_addr_o}, {32'h0, er});
                    end
                    chk("rd_while_busy", {63'h0, bus.rd_busy_i}, 64'h0);
                end
                if (bus.wr_req_o) begin
                    if (wr_q.size() == 0) chk("wr_unexpected", {bus.wr_addr_o, bus.wr_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    else begin
                        ew = wr_q.pop_front();
                        chk("wr_addr_data", {bus.wr_addr_o, bus.wr_data_o}, ew);
                    end
                    chk("wr_while_busy", {63'h0, bus.wr_busy_i}, 64'h0);
                end
                if (bus.rd_req_o || bus.wr_req_o) chk("req_back_to_back", {63'h0, prev_req}, 64'h0);
                if (bus.done_o) begin
                    if (done_q.size() == 0) chk("done_unexpected", 64'h1, 64'h0);
                    else begin
                        ed = done_q.pop_front();
                        chk("done_abort_prevdone_prevstart", {61'h0, bus.aborted_o, pwd, pst}, {61'h0, ed});
                    end
                end
            end
            prev_req = bus.rd_req_o || bus.wr_req_o;
            pwd = bus.wr_done_i;
            pst = bus.start_i;
        end
    end

    task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(s + 32'(4 * i));
            wr_q.push_back({d + 32'(4 * i), mem(s + 32'(4 * i))});
        end
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, input logic ab);
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.abort_i = ab;
        bus.src_addr_i = s;
        bus.dst_addr_i = d;
        bus.len_i = n;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int first_rd, output int done_cyc);
        first_rd = -1;
        done_cyc = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (bus.rd_req_o && first_rd < 0) first_rd = cyc;
            if (bus.done_o) begin
                done_cyc = cyc;
                break;
            end
        end
        tests++;
        if (done_cyc < 0) begin
            fails++;
            $display("FAIL done_timeout: no done within %0d cycles", lim);
        end
    endtask

    initial begin
        int fr, dc;
        bus.start_i = 0; bus.abort_i = 0; bus.src_addr_i = 0; bus.dst_addr_i = 0; bus.len_i = 0;
        bus.rd_busy_i = 0; bus.rd_valid_i = 0; bus.rd_data_i = 0; bus.wr_busy_i = 0; bus.wr_done_i = 0;
`ifdef NDMA_XFER_IRQ_EN
        bus.irq_clr_i = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'h0, bus.busy_o}, 64'h0);
        chk("rst_done", {63'h0, bus.done_o}, 64'h0);
        chk("rst_reqs", {62'h0, bus.rd_req_o, bus.wr_req_o}, 64'h0);
        chk("rst_addrs", {bus.rd_addr_o, bus.wr_addr_o}, 64'h0);
        chk("rst_wdata_aborted", {31'h0, bus.wr_data_o, bus.aborted_o}, 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // nominal 3-word copy
        expect_copy(32'h1000, 32'h2000, 3);
        done_q.push_back(3'b010);
        start_xfer(32'h1000, 32'h2000, 16'd3, 1'b0);
        wait_done(100, fr, dc);
        chk("nominal_first_rd_to_done", 64'(dc - fr), 64'd12);

        // zero length
        done_q.push_back(3'b001);
        start_xfer(32'h5000, 32'h6000, 16'd0, 1'b0);
        @(negedge clk);
        chk("len0_done_next_cycle", {63'h0, bus.done_o}, 64'h1);
        chk("len0_busy_in_fin", {63'h0, bus.busy_o}, 64'h1);
        @(negedge clk);
        chk("len0_idle_after", {62'h0, bus.busy_o, bus.aborted_o}, 64'h0);

        // backpressure: read busy 5 cycles, then write busy 3 cycles
        bus.rd_busy_i = 1'b1;
        bus.wr_busy_i = 1'b1;
        expect_copy(32'h3000, 32'h4000, 1);
        done_q.push_back(3'b010);
        start_xfer(32'h3000, 32'h4000, 16'd1, 1'b0);
        repeat (5) @(posedge clk);
        #1 bus.rd_busy_i = 1'b0;
        @(negedge clk);
        chk("bp_rd_on_release", {63'h0, bus.rd_req_o}, 64'h1);
        repeat (5) @(posedge clk);
        #1 bus.wr_busy_i = 1'b0;
        @(negedge clk);
        chk("bp_wr_on_release", {63'h0, bus.wr_req_o}, 64'h1);
        wait_done(50, fr, dc);

        // address wrap, with a stray start mid-transfer that must be ignored
        expect_copy(32'hFFFF_FFFC, 32'h0000_0010, 2);
        done_q.push_back(3'b010);
        start_xfer(32'hFFFF_FFFC, 32'h0000_0010, 16'd2, 1'b0);
        start_xfer(32'h7777_0000, 32'h8888_0000, 16'd5, 1'b0);
        wait_done(50, fr, dc);

        // abort in RD_WAIT of word 2 of 4
        expect_copy(32'hA000, 32'hB000, 2);
        done_q.push_back(3'b110);
        start_xfer(32'hA000, 32'hB000, 16'd4, 1'b0);
        fr = 0;
        for (int i = 0; i < 50 && fr < 2; i++) begin
            @(negedge clk);
            if (bus.rd_req_o) fr++;
        end
        chk("abort_second_read_seen", 64'(fr), 64'd2);
        @(posedge clk);
        #1 bus.abort_i = 1'b1;
        @(posedge clk);
        #1 bus.abort_i = 1'b0;
        wait_done(50, fr, dc);
        @(negedge clk);
        chk("abort_sticky", {63'h0, bus.aborted_o}, 64'h1);

        // start with simultaneous abort: start wins and clears aborted
        expect_copy(32'hC000, 32'hD000, 1);
        done_q.push_back(3'b010);
        start_xfer(32'hC000, 32'hD000, 16'd1, 1'b1);
        @(negedge clk);
        chk("start_clears_aborted", {63'h0, bus.aborted_o}, 64'h0);
        wait_done(50, fr, dc);

`ifdef NDMA_XFER_IRQ_EN
        done_q.push_back(3'b001);
        start_xfer(32'h0, 32'h0, 16'd0, 1'b0);
        @(negedge clk);
        chk("irq_with_done", {62'h0, bus.irq_o, bus.done_o}, 64'h3);
        repeat (3) @(negedge clk);
        chk("irq_held", {63'h0, bus.irq_o}, 64'h1);
        @(posedge clk);
        #1 bus.irq_clr_i = 1'b1;
        @(posedge clk);
        #1 bus.irq_clr_i = 1'b0;
        @(negedge clk);
        chk("irq_cleared", {63'h0, bus.irq_o}, 64'h0);
        done_q.push_back(3'b001);
        start_xfer(32'h0, 32'h0, 16'd0, 1'b0);
        bus.irq_clr_i = 1'b1;
        @(negedge clk);
        chk("irq_set_vs_clr_same", {62'h0, bus.irq_o, bus.done_o}, 64'h3);
        @(posedge clk);
        #1 bus.irq_clr_i = 1'b0;
        @(negedge clk);
        chk("irq_set_wins", {63'h0, bus.irq_o}, 64'h1);
`endif

        repeat (4) @(negedge clk);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        chk("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
